// File: rtl/mul_hilo_pkg.sv
// mul_hilo_pkg
//   Shared definitions for the HI/LO multiply controller:
//   - op_code encodings (4 bits)
//   - FSM state encoding
//   - accumulate-kind encoding, used only when MUL_HILO_MADD_EN is defined
//   - decode helpers for "starts a multiply" and "signed multiply"
// Optional feature macro: MUL_HILO_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package mul_hilo_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MUL_HILO_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mul_hilo_ctrl_hilo_reg.sv
// hilo_reg
//   Architectural HI/LO storage. Each half has its own write enable so
//   MTHI/MTLO can update one half while a multiply writes both.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   hi_we/lo_we  write enables
//   hi_d/lo_d    write data
//   hi_q/lo_q    current HI/LO
module hilo_reg #(
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_d,
  input  logic [31:0] lo_d,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= HILO_RST;
      r_lo <= HILO_RST;
    end else begin
      if (hi_we) r_hi <= hi_d;
      if (lo_we) r_lo <= lo_d;
    end
  end

  assign hi_q = r_hi;
  assign lo_q = r_lo;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl
//   Execute-stage controller around a 2-cycle pipelined multiplier.
//   Issues MULT/MULTU, holds operands stable until the result returns,
//   stalls the pipeline meanwhile, and writes the product into HI/LO.
//   Also executes MTHI/MTLO, forwards flush as mul_interrupt, and aborts
//   with a sticky timeout_err if the multiplier never answers.
// Optional feature macro: MUL_HILO_MADD_EN adds MADD/MADDU/MSUB/MSUBU,
//   which accumulate the product into {hi,lo}.
//
//   state | meaning
//   IDLE  | no multiply in flight; issue / MTHI / MTLO accepted
//   BUSY  | multiply in flight; waiting for mul_data_ok, flush or timeout
//
// Ports:
//   clk, rst               clock, async active-low reset
//   flush                  pipeline flush (also aborts the multiplier)
//   op_valid, op_code      execute-stage instruction
//   rs_val, rt_val         operands
//   stall                  holds upstream pipeline
//   mul_en, mul_a, mul_b, mul_sign, mul_interrupt   to multiplier
//   mul_data_ok, mul_result                        from multiplier
//   hi, lo                 architectural HI/LO
//   timeout_err            sticky missing-result flag
module mul_hilo_ctrl
  import mul_hilo_pkg::*;
#(
  parameter int          TIMEOUT  = 4,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic        mul_en,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_sign,
  output logic        mul_interrupt,
  input  logic        mul_data_ok,
  input  logic [63:0] mul_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        timeout_err
);

  localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic          r_sign;
  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;

  logic          w_is_mul;
  logic          w_issue;
  logic          w_timeout_hit;
  logic          w_hi_we;
  logic          w_lo_we;
  logic [31:0]   w_hi_d;
  logic [31:0]   w_lo_d;
  logic [63:0]   w_wr;
  logic          w_idle_drive;

  assign w_is_mul = is_mul_op(op_code);

`ifdef MUL_HILO_MADD_EN
  acc_t r_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= ACC_NONE;
    end else if (w_issue) begin
      if (op_code == OP_MADD || op_code == OP_MADDU)      r_acc <= ACC_ADD;
      else if (op_code == OP_MSUB || op_code == OP_MSUBU) r_acc <= ACC_SUB;
      else                                                r_acc <= ACC_NONE;
    end
  end

  // 64-bit modulo accumulate against the current HI/LO pair.
  always_comb begin
    w_wr = mul_result;
    case (r_acc)
      ACC_ADD: w_wr = {hi, lo} + mul_result;
      ACC_SUB: w_wr = {hi, lo} - mul_result;
      default: w_wr = mul_result;
    endcase
  end
`else
  assign w_wr = mul_result;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    stall         = 1'b0;
    mul_en        = 1'b0;
    w_issue       = 1'b0;
    w_timeout_hit = 1'b0;
    w_hi_we       = 1'b0;
    w_lo_we       = 1'b0;
    w_hi_d        = rs_val;
    w_lo_d        = rs_val;
    case (r_state)
      IDLE: begin
        if (op_valid && !flush) begin
          if (w_is_mul) begin
            w_issue     = 1'b1;
            mul_en      = 1'b1;
            stall       = 1'b1;
            w_state_nxt = BUSY;
          end else if (op_code == OP_MTHI) begin
            w_hi_we = 1'b1;
          end else if (op_code == OP_MTLO) begin
            w_lo_we = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = ~mul_data_ok;
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (mul_data_ok) begin
          w_state_nxt = IDLE;
          w_hi_we     = 1'b1;
          w_lo_we     = 1'b1;
          w_hi_d      = w_wr[63:32];
          w_lo_d      = w_wr[31:0];
        end else if (r_cnt == TO_LAST) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // In IDLE the operands pass straight through so the issue cycle sees
  // them; gating by op_valid keeps the interface quiet when nothing is valid.
  assign w_idle_drive  = (r_state == IDLE) && op_valid;
  assign mul_a         = (r_state == IDLE) ? (w_idle_drive ? rs_val : 32'h0) : r_a;
  assign mul_b         = (r_state == IDLE) ? (w_idle_drive ? rt_val : 32'h0) : r_b;
  assign mul_sign      = (r_state == IDLE) ? (w_idle_drive && is_signed_op(op_code)) : r_sign;
  assign mul_interrupt = flush | w_timeout_hit;
  assign timeout_err   = r_timeout_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_a           <= 32'h0;
      r_b           <= 32'h0;
      r_sign        <= 1'b0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_a    <= rs_val;
        r_b    <= rt_val;
        r_sign <= is_signed_op(op_code);
        r_cnt  <= '0;
      end else if (r_state == BUSY && !mul_data_ok) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_timeout_hit) r_timeout_err <= 1'b1;
    end
  end

  hilo_reg #(.HILO_RST(HILO_RST)) u_hilo (
    .clk   (clk),
    .rst   (rst),
    .hi_we (w_hi_we),
    .lo_we (w_lo_we),
    .hi_d  (w_hi_d),
    .lo_d  (w_lo_d),
    .hi_q  (hi),
    .lo_q  (lo)
  );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
module tb_mul_hilo_ctrl;
  import mul_hilo_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic        mul_en;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sign;
  logic        mul_interrupt;
  logic        mul_data_ok;
  logic [63:0] mul_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        timeout_err;

  int n_checks;
  int n_fail;

  mul_hilo_ctrl #(.TIMEOUT(4), .HILO_RST(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .op_valid      (op_valid),
    .op_code       (op_code),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .stall         (stall),
    .mul_en        (mul_en),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_sign      (mul_sign),
    .mul_interrupt (mul_interrupt),
    .mul_data_ok   (mul_data_ok),
    .mul_result    (mul_result),
    .hi            (hi),
    .lo            (lo),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, then settle before checks.
  task automatic cyc(input logic ov, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic fl, input logic dok,
                     input logic [63:0] res);
    @(negedge clk);
    op_valid    = ov;
    op_code     = op;
    rs_val      = a;
    rt_val      = b;
    flush       = fl;
    mul_data_ok = dok;
    mul_result  = res;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    op_valid = 0; op_code = OP_NOP; rs_val = 0; rt_val = 0;
    flush = 0; mul_data_ok = 0; mul_result = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hilo got=%h exp=%h", {hi, lo}, 64'h0);
    end
    n_checks++;
    if ({stall, mul_en, mul_sign, mul_interrupt, timeout_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=00000",
                         {stall, mul_en, mul_sign, mul_interrupt, timeout_err});
    end
    n_checks++;
    if ({mul_a, mul_b} !== 64'h0) begin
      n_fail++; $display("FAIL reset_operands got=%h exp=0", {mul_a, mul_b});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mult;
    cyc(1, OP_MULT, 32'hFFFFFFFE, 32'd3, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_en, mul_interrupt} !== 3'b110) begin
      n_fail++; $display("FAIL mult_issue_ctrl got=%b exp=110", {stall, mul_en, mul_interrupt});
    end
    n_checks++;
    if ({mul_a, mul_b, mul_sign} !== {32'hFFFFFFFE, 32'd3, 1'b1}) begin
      n_fail++; $display("FAIL mult_issue_ops got=%h/%h/%b exp=fffffffe/00000003/1",
                         mul_a, mul_b, mul_sign);
    end
    cyc(1, OP_MULT, 32'hFFFFFFFE, 32'd3, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_en} !== 2'b10) begin
      n_fail++; $display("FAIL mult_t1_ctrl got=%b exp=10", {stall, mul_en});
    end
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 1, 64'hFFFFFFFF_FFFFFFFA);
    n_checks++;
    if ({stall, mul_a, mul_b, mul_sign} !== {1'b0, 32'hFFFFFFFE, 32'd3, 1'b1}) begin
      n_fail++; $display("FAIL mult_t2 got stall=%b a=%h b=%h s=%b exp 0/fffffffe/00000003/1",
                         stall, mul_a, mul_b, mul_sign);
    end
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin
      n_fail++; $display("FAIL mult_result got=%h exp=fffffffffffffffa", {hi, lo});
    end
    n_checks++;
    if ({stall, mul_en} !== 2'b00) begin
      n_fail++; $display("FAIL mult_t3_ctrl got=%b exp=00", {stall, mul_en});
    end
  endtask

  task automatic test_multu_hold;
    cyc(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_en, mul_sign} !== 3'b110) begin
      n_fail++; $display("FAIL multu_issue got=%b exp=110", {stall, mul_en, mul_sign});
    end
    cyc(1, OP_MULTU, 32'h12345678, 32'h00000001, 0, 0, 64'h0);
    n_checks++;
    if ({mul_a, mul_b} !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin
      n_fail++; $display("FAIL multu_hold got=%h/%h exp=ffffffff/ffffffff", mul_a, mul_b);
    end
    cyc(0, OP_NOP, 32'hDEADBEEF, 32'h0, 0, 1, 64'hFFFFFFFE_00000001);
    n_checks++;
    if ({stall, mul_a, mul_sign} !== {1'b0, 32'hFFFFFFFF, 1'b0}) begin
      n_fail++; $display("FAIL multu_t2 got stall=%b a=%h s=%b exp 0/ffffffff/0",
                         stall, mul_a, mul_sign);
    end
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
      n_fail++; $display("FAIL multu_result got=%h exp=fffffffe00000001", {hi, lo});
    end
  endtask

  task automatic test_mthi_mtlo;
    cyc(1, OP_MTHI, 32'h12345678, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_en} !== 2'b00) begin
      n_fail++; $display("FAIL mthi_ctrl got=%b exp=00", {stall, mul_en});
    end
    cyc(1, OP_MTLO, 32'h9ABCDEF0, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if ({stall, hi, lo} !== {1'b0, 32'h12345678, 32'h00000001}) begin
      n_fail++; $display("FAIL mthi_write got stall=%b hi=%h lo=%h exp 0/12345678/00000001",
                         stall, hi, lo);
    end
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if ({hi, lo} !== {32'h12345678, 32'h9ABCDEF0}) begin
      n_fail++; $display("FAIL mtlo_write got=%h exp=123456789abcdef0", {hi, lo});
    end
  endtask

  task automatic test_flush;
    cyc(1, OP_MULT, 32'd5, 32'd7, 1, 0, 64'h0);
    n_checks++;
    if ({stall, mul_en, mul_interrupt} !== 3'b001) begin
      n_fail++; $display("FAIL flush_idle got=%b exp=001", {stall, mul_en, mul_interrupt});
    end
    cyc(1, OP_MULT, 32'd5, 32'd7, 0, 0, 64'h0);
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    cyc(0, OP_NOP, 32'h0, 32'h0, 1, 1, 64'd35);
    n_checks++;
    if ({stall, mul_interrupt} !== 2'b01) begin
      n_fail++; $display("FAIL flush_busy got=%b exp=01", {stall, mul_interrupt});
    end
    cyc(1, OP_MTHI, 32'hCAFEF00D, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_interrupt, hi, lo} !== {2'b00, 32'h12345678, 32'h9ABCDEF0}) begin
      n_fail++; $display("FAIL flush_nowrite got stall=%b int=%b hi=%h lo=%h exp 0/0/12345678/9abcdef0",
                         stall, mul_interrupt, hi, lo);
    end
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if (hi !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL flush_idle_after got hi=%h exp=cafef00d", hi);
    end
  endtask

  task automatic test_timeout;
    cyc(1, OP_MULT, 32'd1, 32'd1, 0, 0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
      n_checks++;
      if ({stall, mul_interrupt, timeout_err} !== 3'b100) begin
        n_fail++; $display("FAIL timeout_wait%0d got=%b exp=100", i, {stall, mul_interrupt, timeout_err});
      end
    end
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_interrupt, timeout_err} !== 3'b110) begin
      n_fail++; $display("FAIL timeout_hit got=%b exp=110", {stall, mul_interrupt, timeout_err});
    end
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_interrupt, timeout_err, hi, lo} !== {3'b001, 32'hCAFEF00D, 32'h9ABCDEF0}) begin
      n_fail++; $display("FAIL timeout_after got=%b hi=%h lo=%h exp 001/cafef00d/9abcdef0",
                         {stall, mul_interrupt, timeout_err}, hi, lo);
    end
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err);
    end
  endtask

  task automatic test_reset_mid_busy;
    cyc(1, OP_MULT, 32'd9, 32'd9, 0, 0, 64'h0);
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({stall, mul_en, mul_interrupt, timeout_err, hi, lo, mul_a} !== {4'b0, 32'h0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_busy got ctrl=%b hi=%h lo=%h a=%h exp all 0",
                         {stall, mul_en, mul_interrupt, timeout_err}, hi, lo, mul_a);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_madd;
`ifdef MUL_HILO_MADD_EN
    cyc(1, OP_MTLO, 32'd5, 32'h0, 0, 0, 64'h0);
    cyc(1, OP_MADD, 32'd2, 32'd3, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_en, mul_sign, hi, lo} !== {3'b111, 32'h0, 32'd5}) begin
      n_fail++; $display("FAIL madd_issue got=%b hi=%h lo=%h exp 111/0/5", {stall, mul_en, mul_sign}, hi, lo);
    end
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 1, 64'd6);
    cyc(1, OP_MSUBU, 32'd4, 32'd4, 0, 0, 64'h0);
    n_checks++;
    if ({hi, lo} !== 64'd11) begin
      n_fail++; $display("FAIL madd_result got=%h exp=%h", {hi, lo}, 64'd11);
    end
    n_checks++;
    if ({stall, mul_en, mul_sign} !== 3'b110) begin
      n_fail++; $display("FAIL msubu_issue got=%b exp=110", {stall, mul_en, mul_sign});
    end
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 1, 64'd16);
    cyc(0, OP_NOP, 32'h0, 32'h0, 0, 0, 64'h0);
    n_checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFB) begin
      n_fail++; $display("FAIL msubu_result got=%h exp=fffffffffffffffb", {hi, lo});
    end
`else
    cyc(1, OP_MADD, 32'd2, 32'd3, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_en} !== 2'b00) begin
      n_fail++; $display("FAIL madd_nop got=%b exp=00", {stall, mul_en});
    end
    cyc(1, OP_MSUBU, 32'd4, 32'd4, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_en} !== 2'b00) begin
      n_fail++; $display("FAIL msubu_nop got=%b exp=00", {stall, mul_en});
    end
    cyc(1, 4'hF, 32'd4, 32'd4, 0, 0, 64'h0);
    n_checks++;
    if ({stall, mul_en, hi, lo} !== {2'b00, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL undef_op got=%b hi=%h lo=%h exp 00/0/0", {stall, mul_en}, hi, lo);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_mult;
    test_multu_hold;
    test_mthi_mtlo;
    test_flush;
    test_timeout;
    test_reset_mid_busy;
    test_madd;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_hilo_ctrl.md
Name: mul_hilo_ctrl

Overview:
- Execute-stage controller that sits directly upstream and downstream of the 2-cycle pipelined multiplier (mul).
- Issues MULT/MULTU operations to the multiplier and holds operands stable for the whole operation.
- Stalls the pipeline until the multiplier returns its result, then captures the 64-bit product into the architectural HI/LO registers.
- Also executes MTHI/MTLO, propagates flush to the multiplier, and detects a missing result with a timeout.

Parameters:
- TIMEOUT, 4: maximum number of BUSY cycles to wait for mul_data_ok before aborting (must be ≥3).
- HILO_RST, 32'h0: reset value of HI and LO.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- flush  in  1  exception/flush from the pipeline.
- op_valid  in  1  execute-stage instruction is valid.
- op_code  in  4  operation code; encodings defined in the package.
- rs_val  in  32  rs operand.
- rt_val  in  32  rt operand.
- stall  out  1  holds the upstream pipeline.
- mul_en  out  1  start request to the multiplier.
- mul_a  out  32  multiplier operand a.
- mul_b  out  32  multiplier operand b.
- mul_sign  out  1  1 = signed multiply.
- mul_interrupt  out  1  abort request to the multiplier.
- mul_data_ok  in  1  multiplier result valid.
- mul_result  in  64  multiplier product.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.
- timeout_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; hi=lo=HILO_RST; timeout_err=0.
  - Operand registers cleared; timeout counter cleared.
  - All combinational outputs are driven 0 while in IDLE with op_valid=0.
- FSM states: IDLE, BUSY.
- is_mul = op_code is MULT or MULTU (plus the accumulate ops when MADD_EN is defined).
- IDLE, op_valid & is_mul & ~flush:
  - mul_en=1; stall=1.
  - Operands latched into a_q/b_q/sign_q.
  - Next state BUSY; counter cleared to 0.
- Operand hold:
  - mul_a = (state==IDLE) ? rs_val : a_q; same form for mul_b and mul_sign.
  - Values are constant from the issue cycle through the mul_data_ok cycle, as the multiplier's output sign correction requires.
- BUSY:
  - stall = ~mul_data_ok.
  - On mul_data_ok & ~flush: HI/LO are written at that edge and the next state is IDLE.
  - The upstream pipeline advances on that same edge.
- Latency:
  - Issue at cycle T; mul_data_ok at T+2; stall is high in T and T+1 and low in T+2.
  - New hi/lo are visible at T+3.
- MULT/MULTU write: {hi,lo} <= mul_result.
- MTHI/MTLO:
  - Execute only in IDLE, with op_valid & ~flush.
  - hi <= rs_val (MTHI) or lo <= rs_val (MTLO) at the same edge; no stall.
- Flush:
  - mul_interrupt = flush, in any state.
  - Next state IDLE; no HI/LO write, including when mul_data_ok arrives in the same cycle.
  - In IDLE, flush suppresses mul_en and stall.
- Timeout:
  - The counter increments every BUSY cycle without mul_data_ok.
  - If it reaches TIMEOUT-1: timeout_err <= 1 (sticky until reset), mul_interrupt=1 for that cycle, next state IDLE, no write.
- Other behaviour:
  - op_code NOP or any undefined encoding: no action.
  - op_valid while BUSY is ignored, because the upstream pipeline is stalled.

Optional Feature:
- Macro: MUL_HILO_MADD_EN.
- Defined:
  - Adds MADD, MADDU, MSUB and MSUBU. They issue exactly like MULT/MULTU (signed for MADD/MSUB).
  - On write: {hi,lo} <= {hi,lo} ± mul_result, computed with a 64-bit modulo add/subtract. The op kind is latched at issue.
- Undefined:
  - These encodings are treated as NOP and no accumulator adder is instantiated.

Decomposition:
- Package mul_hilo_pkg holds:
  - op_code localparams: OP_NOP=0, OP_MULT=1, OP_MULTU=2, OP_MTHI=3, OP_MTLO=4, OP_MADD=5, OP_MADDU=6, OP_MSUB=7, OP_MSUBU=8.
  - FSM state encoding: IDLE=1'b0, BUSY=1'b1.
- Sub-module hilo_reg: HI/LO storage with async active-low reset, separate hi_we/lo_we enables and data inputs.

Test Plan:
- MULT rs=32'hFFFFFFFE (-2), rt=3 → stall high for 2 cycles, mul_en high 1 cycle; at T+3 hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- MULTU rs=rt=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001. Also change rs_val in T+1; mul_a must stay 32'hFFFFFFFF.
- MTHI rs=32'h12345678, then MTLO rs=32'h9ABCDEF0 in consecutive cycles → no stall; hi/lo updated next cycles.
- MULT issued, flush asserted in T+2 together with mul_data_ok → hi/lo unchanged, state IDLE, mul_interrupt=1 that cycle.
- Model holds mul_data_ok low → timeout_err=1 after TIMEOUT BUSY cycles, stall released, hi/lo unchanged. Assert rst=0 mid-BUSY → immediate IDLE, hi=lo=0.
- With MUL_HILO_MADD_EN defined: hi=0, lo=5, MADD 2×3 → lo=11. Then MSUBU 4×4 → {hi,lo}=64'hFFFFFFFF_FFFFFFFB.
